// File: rtl/icache_refill_pkg.sv
// icache_refill_pkg: shared state encoding and constants for the instruction-cache refill buffer
package icache_refill_pkg;
  typedef enum logic [1:0] {
    REFILL_IDLE   = 2'd0,
    REFILL_FETCH  = 2'd1,
    REFILL_STREAM = 2'd2
  } refill_state_t;
  localparam int MAX_BURST_DEF = 16;
  localparam int WORD_BYTES = 4;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
endpackage

// File: rtl/refill_word_buffer.sv
// refill_word_buffer: burst word store with one synchronous write port and one combinational read port
module refill_word_buffer #(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  // capture one fetched word per write strobe; contents are deliberately not reset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/icache_refill_buffer.sv
// icache_refill_buffer: collects a burst word-by-word from memory, then streams it gap-free to the L1 refill port (optional ICACHE_REFILL_TIMEOUT_EN adds ack timeout and bus_err)
module icache_refill_buffer
  import icache_refill_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
`ifdef ICACHE_REFILL_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        l2_rreq,
  input  logic [31:0] l2_addr,
  input  logic [4:0]  l2_burst_size,
  output logic [31:0] l2_rdata,
  output logic        l2_busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef ICACHE_REFILL_TIMEOUT_EN
  , output logic      bus_err
`endif
);
  localparam int IW = $clog2(MAX_BURST);
  localparam int LW = $clog2(MAX_BURST + 1);
  refill_state_t state, state_n;
  logic [LW-1:0] len, len_n, wr_idx, wr_idx_n, rd_idx, rd_idx_n, req_len;
  logic [31:0]   mem_addr_n, buf_rdata;
  logic          mem_req_n, busy_n, acked, last_ack, timeout;
  assign req_len  = (32'(l2_burst_size) > MAX_BURST) ? LW'(MAX_BURST) : LW'(l2_burst_size);
  assign acked    = state == REFILL_FETCH && mem_req && mem_ack;
  assign last_ack = acked && wr_idx == len - LW'(1);
  refill_word_buffer #(.DEPTH(MAX_BURST), .AW(IW)) u_buf (
    .clk   (clk),
    .we    (acked && !reset),
    .waddr (wr_idx[IW-1:0]),
    .wdata (mem_rdata),
    .raddr (rd_idx[IW-1:0]),
    .rdata (buf_rdata)
  );
`ifdef ICACHE_REFILL_TIMEOUT_EN
  logic [7:0] wait_cnt;
  assign timeout = state == REFILL_FETCH && mem_req && !mem_ack && wait_cnt + 8'd1 == 8'(TIMEOUT);
  // slots never written after a timeout read back as NOP instead of stale data
  assign l2_rdata = state != REFILL_STREAM ? NOP_WORD : rd_idx < wr_idx ? buf_rdata : NOP_WORD;
  // per-word ack wait counter and sticky timeout flag
  always_ff @(posedge clk)
    if (reset) begin
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      wait_cnt <= (acked || (state == REFILL_IDLE && l2_rreq)) ? 8'd0 :
                  (state == REFILL_FETCH && mem_req) ? wait_cnt + 8'd1 : wait_cnt;
      bus_err  <= bus_err | timeout;
    end
`else
  assign timeout  = 1'b0;
  assign l2_rdata = state == REFILL_STREAM ? buf_rdata : NOP_WORD;
`endif
  // next-state and next-output logic for the idle/fetch/stream sequence
  always_comb begin
    state_n    = state;
    len_n      = len;
    wr_idx_n   = wr_idx;
    rd_idx_n   = rd_idx;
    mem_req_n  = mem_req;
    mem_addr_n = mem_addr;
    busy_n     = l2_busy;
    if (state == REFILL_IDLE && l2_rreq) begin
      state_n    = REFILL_FETCH;
      len_n      = req_len;
      wr_idx_n   = '0;
      mem_addr_n = l2_addr & ~32'h3;
      mem_req_n  = req_len != '0;
      busy_n     = 1'b1;
    end
    if (state == REFILL_FETCH && len == '0) begin
      state_n = REFILL_IDLE;
      busy_n  = 1'b0;
    end
    if (acked) begin
      wr_idx_n   = wr_idx + LW'(1);
      mem_addr_n = mem_addr + 32'(WORD_BYTES);
    end
    if (last_ack || timeout) begin
      state_n   = REFILL_STREAM;
      mem_req_n = 1'b0;
      busy_n    = 1'b0;
      rd_idx_n  = '0;
    end
    if (state == REFILL_STREAM) begin
      rd_idx_n = rd_idx + LW'(1);
      state_n  = rd_idx == len - LW'(1) ? REFILL_IDLE : REFILL_STREAM;
    end
  end
  // state and registered outputs; reset wins over a concurrent ack
  always_ff @(posedge clk)
    if (reset) begin
      state    <= REFILL_IDLE;
      len      <= '0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      l2_busy  <= 1'b0;
    end else begin
      state    <= state_n;
      len      <= len_n;
      wr_idx   <= wr_idx_n;
      rd_idx   <= rd_idx_n;
      mem_req  <= mem_req_n;
      mem_addr <= mem_addr_n;
      l2_busy  <= busy_n;
    end
endmodule

// File: tb/tb_icache_refill_buffer.sv
// tb_icache_refill_buffer: directed bench for the refill buffer (timeout case built when ICACHE_REFILL_TIMEOUT_EN is defined)
module tb_icache_refill_buffer;
  logic        clk = 1'b0, reset = 1'b1, l2_rreq = 1'b0, mem_ack = 1'b0;
  logic [31:0] l2_addr = '0, mem_rdata = '0;
  logic [4:0]  l2_burst_size = '0;
  logic [31:0] l2_rdata, mem_addr;
  logic        l2_busy, mem_req;
  int          total = 0, bad = 0;
`ifdef ICACHE_REFILL_TIMEOUT_EN
  logic        bus_err;
`endif
  icache_refill_buffer #(
    .MAX_BURST(16)
`ifdef ICACHE_REFILL_TIMEOUT_EN
    , .TIMEOUT(10)
`endif
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .l2_rreq       (l2_rreq),
    .l2_addr       (l2_addr),
    .l2_burst_size (l2_burst_size),
    .l2_rdata      (l2_rdata),
    .l2_busy       (l2_busy),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack)
`ifdef ICACHE_REFILL_TIMEOUT_EN
    , .bus_err     (bus_err)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic burst(input logic [31:0] base, input logic [4:0] size, input int maxdly, input int abort_after, input logic poke);
    int n, d;
    logic [31:0] a;
    n = size > 5'd16 ? 16 : int'(size);
    l2_addr = base;
    l2_burst_size = size;
    l2_rreq = 1'b1;
    tick;
    l2_rreq = 1'b0;
    chk("busy_on", 32'(l2_busy), 32'd1);
    chk("req_on", 32'(mem_req), 32'(n != 0));
    if (n == 0) begin
      tick;
      chk("zero_idle", 32'(l2_busy), 32'd0);
      chk("zero_noreq", 32'(mem_req), 32'd0);
      chk("zero_rdata", l2_rdata, 32'd0);
      return;
    end
    a = base & ~32'h3;
    for (int i = 0; i < n; i++) begin
      d = maxdly > 0 ? int'($urandom_range(maxdly, 0)) : 0;
      for (int k = 0; k < d; k++) begin
        chk("wait_busy", 32'(l2_busy), 32'd1);
        chk("wait_req", 32'(mem_req), 32'd1);
        l2_rreq = poke;
        tick;
        l2_rreq = 1'b0;
      end
      chk("addr", mem_addr, a);
      chk("busy", 32'(l2_busy), 32'd1);
      chk("req", 32'(mem_req), 32'd1);
      mem_ack = 1'b1;
      mem_rdata = pat(a);
      l2_rreq = poke;
      tick;
      mem_ack = 1'b0;
      l2_rreq = 1'b0;
      a += 32'd4;
      if (i + 1 == abort_after) begin
        reset = 1'b1;
        mem_ack = 1'b1;
        tick;
        reset = 1'b0;
        mem_ack = 1'b0;
        chk("abort_busy", 32'(l2_busy), 32'd0);
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_addr", mem_addr, 32'd0);
        chk("abort_rdata", l2_rdata, 32'd0);
        return;
      end
    end
    chk("busy_off", 32'(l2_busy), 32'd0);
    chk("req_off", 32'(mem_req), 32'd0);
    a = base & ~32'h3;
    for (int i = 0; i < n; i++) begin
      chk("data", l2_rdata, pat(a));
      chk("stream_busy", 32'(l2_busy), 32'd0);
      a += 32'd4;
      l2_rreq = poke;
      tick;
      l2_rreq = 1'b0;
    end
    chk("end_rdata", l2_rdata, 32'd0);
    chk("end_busy", 32'(l2_busy), 32'd0);
    chk("end_req", 32'(mem_req), 32'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tick;
    tick;
    chk("rst_busy", 32'(l2_busy), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rdata", l2_rdata, 32'd0);
`ifdef ICACHE_REFILL_TIMEOUT_EN
    chk("rst_err", 32'(bus_err), 32'd0);
`endif
    reset = 1'b0;
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("stray_ack_busy", 32'(l2_busy), 32'd0);
    chk("stray_ack_addr", mem_addr, 32'd0);
    burst(32'h0000_1020, 5'd8, 0, -1, 1'b0);
    chk("addr_after8", mem_addr, 32'h0000_1040);
    burst(32'h0000_1020, 5'd8, 5, -1, 1'b0);
    burst(32'h0000_4000, 5'd20, 0, -1, 1'b0);
    chk("addr_after16", mem_addr, 32'h0000_4040);
    burst(32'h0000_7000, 5'd0, 0, -1, 1'b0);
    burst(32'hFFFF_FFF8, 5'd4, 0, -1, 1'b0);
    chk("addr_wrap", mem_addr, 32'h0000_0008);
    burst(32'h0000_3003, 5'd8, 2, -1, 1'b1);
    burst(32'h0000_5000, 5'd8, 0, 3, 1'b0);
    burst(32'h0000_6004, 5'd2, 1, -1, 1'b0);
`ifdef ICACHE_REFILL_TIMEOUT_EN
    begin
      int cyc;
      logic [31:0] a;
      l2_addr = 32'h0000_2000;
      l2_burst_size = 5'd8;
      l2_rreq = 1'b1;
      tick;
      l2_rreq = 1'b0;
      a = 32'h0000_2000;
      for (int i = 0; i < 2; i++) begin
        mem_ack = 1'b1;
        mem_rdata = pat(a);
        tick;
        mem_ack = 1'b0;
        a += 32'd4;
      end
      cyc = 0;
      while (l2_busy && cyc < 300) begin
        tick;
        cyc++;
      end
      chk("to_cycles", 32'(cyc), 32'd10);
      chk("to_err", 32'(bus_err), 32'd1);
      chk("to_req", 32'(mem_req), 32'd0);
      for (int i = 0; i < 8; i++) begin
        chk("to_data", l2_rdata, i < 2 ? pat(32'h0000_2000 + 32'(4 * i)) : 32'h0);
        tick;
      end
      chk("to_sticky", 32'(bus_err), 32'd1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("to_clear", 32'(bus_err), 32'd0);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
